wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
MEM/WB pipeline register and writeback-select stage of the 5-stage RV32I core. It sits directly upstream of the register file and drives its WB_RegWrite, WB_Write_reg and WB_Write_data inputs. Data-memory reads return over the bus with variable latency, so this stage also:
- buffers early load data,
- raises a load stall until the data arrives,
- performs load byte/halfword extraction and sign extension,
- counts retired instructions for the CSR unit.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
mem_valid  input  1  MEM stage holds a real instruction (not a bubble).
mem_RegWrite  input  1  instruction writes rd.
mem_MemtoReg  input  1  instruction is a load; the result comes from data memory.
mem_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
mem_rd  input  5  destination register index.
mem_alu_out  input  32  ALU result; it is the load address when mem_MemtoReg=1.
dm_rvalid  input  1  data-memory read data valid (one-cycle pulse).
dm_rdata  input  32  data-memory read word.
stall_in  input  1  stall request from other hazard sources.
load_stall  output  1  combinational; freezes IF/ID/EX/MEM while a load is waiting for data.
WB_RegWrite  output  1  register-file write enable.
WB_Write_reg  output  5  register-file write index.
WB_Write_data  output  32  register-file write data.
retire_count  output  CNT_W  count of retired instructions.

Behaviour:
Reset (asynchronous, active-high, effective immediately):
- WB_RegWrite=0, WB_Write_reg=0, WB_Write_data=0, retire_count=0.
- FSM returns to IDLE and the load buffer is cleared, including when rst arrives mid-WAIT or mid-HELD.

Definitions:
- is_load = mem_valid & mem_MemtoReg.
- FSM states:
  - IDLE: no load data held.
  - WAIT: load in MEM, data not yet returned.
  - HELD: data captured in ld_buf, awaiting advance.
- load_stall = is_load & (state!=HELD) & ~dm_rvalid.
- advance = ~stall_in & ~load_stall.

FSM transitions:
- IDLE -> WAIT when is_load & ~dm_rvalid.
- IDLE -> HELD when is_load & dm_rvalid & stall_in; capture dm_rdata into ld_buf.
- WAIT -> HELD when dm_rvalid & stall_in; capture into ld_buf.
- WAIT -> IDLE when dm_rvalid & ~stall_in; data is consumed directly.
- HELD -> IDLE on advance.
- In HELD, further dm_rvalid pulses are ignored and the first captured word is kept.
- dm_rvalid while ~is_load is ignored in every state.

Load data selection and extraction:
- The load word is ld_buf in HELD, else dm_rdata.
- Offset = mem_alu_out[1:0].
- LB/LBU: byte at offset; sign-extended or zero-extended.
- LH/LHU: halfword selected by offset[1]; offset[0] is ignored (no misalignment trap).
- LW, and any other funct3 value: full word.

On each rising edge with advance=1:
- WB_RegWrite <= mem_valid & mem_RegWrite & (mem_rd!=0).
- WB_Write_reg <= mem_rd.
- WB_Write_data <= extracted load data if mem_MemtoReg, else mem_alu_out.
- retire_count += mem_valid; it wraps at 2^CNT_W.

On each rising edge with advance=0:
- WB_RegWrite <= 0, inserting a bubble.
- WB_Write_reg and WB_Write_data hold their values.
- retire_count holds.

Latency and simultaneous events:
- Non-load: 1 cycle from MEM to the WB outputs.
- Load: 1 cycle after the first cycle in which data is available and stall_in=0.
- stall_in and dm_rvalid in the same cycle: data is buffered, never lost.
- load_stall never depends on stall_in, so there is no combinational loop.

Test Plan:
- ALU op with mem_valid=1, mem_RegWrite=1, mem_rd=5, mem_alu_out=0x1234, stall_in=0 -> next cycle WB_RegWrite=1, WB_Write_reg=5, WB_Write_data=0x1234, retire_count=1.
- LB, mem_alu_out=0x...03, dm_rdata=0x80FF_FF7F with dm_rvalid the same cycle -> WB_Write_data=0xFFFF_FF80, load_stall never 1. LBU with the same inputs -> 0x0000_0080.
- LH at offset 2, dm_rvalid arriving 3 cycles late with dm_rdata=0x8001_0000 -> load_stall=1 for exactly 3 cycles and WB_RegWrite=0 during them; then WB_Write_data=0xFFFF_8001.
- LW with dm_rvalid pulse while stall_in=1, stall_in released 2 cycles later -> state HELD, load_stall=0, data 0xDEAD_BEEF written one cycle after release; a second dm_rvalid with 0x0 during HELD is ignored.
- Write to rd=0 with mem_RegWrite=1 -> WB_RegWrite=0, retire_count still increments. Bubble (mem_valid=0) -> no retire.
- rst asserted asynchronously mid-WAIT -> outputs and retire_count zero immediately, state IDLE. After release, a late dm_rvalid with no load in MEM is ignored.

Source files
------------

// File: rtl/wb_stage_if.sv
// Data-memory read-return bus seen by the writeback stage.
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic            dm_rvalid;
  logic [XLEN-1:0] dm_rdata;

  modport master (
    output dm_rvalid,
    output dm_rdata
  );

  modport slave (
    input dm_rvalid,
    input dm_rdata
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback select with variable-latency
// load return, load buffering, byte/half extraction and retire counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_RegWrite,
  input  logic             mem_MemtoReg,
  input  logic [2:0]       mem_funct3,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_alu_out,
  wb_stage_if.slave        dm,
  input  logic             stall_in,
  output logic             load_stall,
  output logic             WB_RegWrite,
  output logic [4:0]       WB_Write_reg,
  output logic [XLEN-1:0]  WB_Write_data,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic            is_load;
  logic            advance;
  logic            capture;
  logic [XLEN-1:0] ld_buf_q, ld_buf_d;
  logic [XLEN-1:0] word;
  logic [XLEN-1:0] ld_data;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;

  logic             we_q, we_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign is_load = mem_valid & mem_MemtoReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (is_load & ~dm.dm_rvalid) begin
          state_d = WAIT;
        end else if (is_load & dm.dm_rvalid & stall_in) begin
          state_d = HELD;
        end
      end
      WAIT: begin
        if (is_load & dm.dm_rvalid) begin
          state_d = stall_in ? HELD : IDLE;
        end
      end
      HELD: begin
        if (advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall never looks at stall_in, so advance has no comb loop.
  always_comb begin
    load_stall = is_load & (state_q != HELD) & ~dm.dm_rvalid;
    advance    = ~stall_in & ~load_stall;
    capture    = is_load & dm.dm_rvalid & stall_in
               & (state_q != HELD);
  end

  always_comb begin
    word    = (state_q == HELD) ? ld_buf_q : dm.dm_rdata;
    byte_s  = word[7:0];
    unique case (mem_alu_out[1:0])
      2'd0: byte_s = word[7:0];
      2'd1: byte_s = word[15:8];
      2'd2: byte_s = word[23:16];
      2'd3: byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    half_s  = mem_alu_out[1] ? word[31:16] : word[15:0];
    ld_data = word;
    unique case (mem_funct3)
      3'b000:  ld_data = {{24{byte_s[7]}}, byte_s};
      3'b001:  ld_data = {{16{half_s[15]}}, half_s};
      3'b100:  ld_data = {24'd0, byte_s};
      3'b101:  ld_data = {16'd0, half_s};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    ld_buf_d = capture ? dm.dm_rdata : ld_buf_q;
    we_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    if (advance) begin
      we_d   = mem_valid & mem_RegWrite & (mem_rd != 5'd0);
      rd_d   = mem_rd;
      data_d = mem_MemtoReg ? ld_data : mem_alu_out;
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, mem_valid};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_buf_q <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      ld_buf_q <= ld_buf_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign WB_RegWrite   = we_q;
  assign WB_Write_reg  = rd_q;
  assign WB_Write_data = data_q;
  assign retire_count  = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_RegWrite;
  logic        mem_MemtoReg;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_out;
  logic        stall_in;
  logic        load_stall;
  logic        WB_RegWrite;
  logic [4:0]  WB_Write_reg;
  logic [31:0] WB_Write_data;
  logic [63:0] retire_count;

  int total;
  int bad;
  longint unsigned exp_cnt;

  wb_stage_if #(.XLEN(32)) dmif ();

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_RegWrite (mem_RegWrite),
    .mem_MemtoReg (mem_MemtoReg),
    .mem_funct3   (mem_funct3),
    .mem_rd       (mem_rd),
    .mem_alu_out  (mem_alu_out),
    .dm           (dmif.slave),
    .stall_in     (stall_in),
    .load_stall   (load_stall),
    .WB_RegWrite  (WB_RegWrite),
    .WB_Write_reg (WB_Write_reg),
    .WB_Write_data(WB_Write_data),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic rv,
                       input logic [31:0] rdata, input logic st);
    mem_valid       = v;
    mem_RegWrite    = rw;
    mem_MemtoReg    = m2r;
    mem_funct3      = f3;
    mem_rd          = rd;
    mem_alu_out     = alu;
    dmif.dm_rvalid  = rv;
    dmif.dm_rdata   = rdata;
    stall_in        = st;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (WB_RegWrite !== 1'b0) begin
      bad++; $display("FAIL rst_we got=%0b exp=0", WB_RegWrite);
    end
    total++;
    if (WB_Write_reg !== 5'd0) begin
      bad++; $display("FAIL rst_reg got=%0d exp=0", WB_Write_reg);
    end
    total++;
    if (WB_Write_data !== 32'h0) begin
      bad++; $display("FAIL rst_data got=%h exp=0", WB_Write_data);
    end
    total++;
    if (retire_count !== 64'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d exp=0", retire_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp_cnt++;
    total++;
    if (WB_RegWrite !== 1'b1 || WB_Write_reg !== 5'd5) begin
      bad++;
      $display("FAIL alu_we_reg got=%0b/%0d exp=1/5",
               WB_RegWrite, WB_Write_reg);
    end
    total++;
    if (WB_Write_data !== 32'h1234) begin
      bad++; $display("FAIL alu_data got=%h exp=00001234", WB_Write_data);
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL alu_cnt got=%0d exp=%0d", retire_count, exp_cnt);
    end
  endtask

  task automatic test_extract();
    logic [2:0]  f3 [6];
    logic [31:0] adr [6];
    logic [31:0] rdw [6];
    logic [31:0] exp [6];
    f3[0] = 3'b000; adr[0] = 32'h103; rdw[0] = 32'h80FF_FF7F;
    exp[0] = 32'hFFFF_FF80;
    f3[1] = 3'b100; adr[1] = 32'h103; rdw[1] = 32'h80FF_FF7F;
    exp[1] = 32'h0000_0080;
    f3[2] = 3'b000; adr[2] = 32'h100; rdw[2] = 32'h80FF_FF7F;
    exp[2] = 32'h0000_007F;
    f3[3] = 3'b101; adr[3] = 32'h101; rdw[3] = 32'h1234_ABCD;
    exp[3] = 32'h0000_ABCD;
    f3[4] = 3'b001; adr[4] = 32'h103; rdw[4] = 32'hF234_ABCD;
    exp[4] = 32'hFFFF_F234;
    f3[5] = 3'b011; adr[5] = 32'h102; rdw[5] = 32'hCAFE_0001;
    exp[5] = 32'hCAFE_0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, f3[i], 5'd3, adr[i], 1'b1, rdw[i], 1'b0);
      #1;
      total++;
      if (load_stall !== 1'b0) begin
        bad++; $display("FAIL ext_stall[%0d] got=%0b exp=0", i, load_stall);
      end
      @(posedge clk); #1;
      exp_cnt++;
      total++;
      if (WB_Write_data !== exp[i] || WB_RegWrite !== 1'b1) begin
        bad++;
        $display("FAIL ext_data[%0d] got=%h/%0b exp=%h/1",
                 i, WB_Write_data, WB_RegWrite, exp[i]);
      end
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_late_load();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd7, 32'h202, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (load_stall !== 1'b1) begin
        bad++; $display("FAIL late_stall[%0d] got=%0b exp=1", i, load_stall);
      end
      @(posedge clk); #1;
      total++;
      if (WB_RegWrite !== 1'b0) begin
        bad++; $display("FAIL late_bubble[%0d] got=%0b exp=0", i, WB_RegWrite);
      end
      @(negedge clk);
    end
    dmif.dm_rvalid = 1'b1;
    dmif.dm_rdata  = 32'h8001_0000;
    #1;
    total++;
    if (load_stall !== 1'b0) begin
      bad++; $display("FAIL late_release got=%0b exp=0", load_stall);
    end
    @(posedge clk); #1;
    exp_cnt++;
    total++;
    if (WB_Write_data !== 32'hFFFF_8001 || WB_Write_reg !== 5'd7
        || WB_RegWrite !== 1'b1) begin
      bad++;
      $display("FAIL late_data got=%h/%0d/%0b exp=ffff8001/7/1",
               WB_Write_data, WB_Write_reg, WB_RegWrite);
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL late_cnt got=%0d exp=%0d", retire_count, exp_cnt);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_held();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd9, 32'h300, 1'b1, 32'hDEAD_BEEF, 1'b1);
    #1;
    total++;
    if (load_stall !== 1'b0) begin
      bad++; $display("FAIL held_stall0 got=%0b exp=0", load_stall);
    end
    @(posedge clk); #1;
    total++;
    if (WB_RegWrite !== 1'b0) begin
      bad++; $display("FAIL held_bubble0 got=%0b exp=0", WB_RegWrite);
    end
    @(negedge clk);
    dmif.dm_rvalid = 1'b1;
    dmif.dm_rdata  = 32'h0;
    #1;
    total++;
    if (load_stall !== 1'b0) begin
      bad++; $display("FAIL held_stall1 got=%0b exp=0", load_stall);
    end
    @(posedge clk); #1;
    total++;
    if (WB_RegWrite !== 1'b0 || retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL held_bubble1 got=%0b/%0d exp=0/%0d",
               WB_RegWrite, retire_count, exp_cnt);
    end
    @(negedge clk);
    dmif.dm_rvalid = 1'b0;
    stall_in       = 1'b0;
    #1;
    total++;
    if (load_stall !== 1'b0) begin
      bad++; $display("FAIL held_stall2 got=%0b exp=0", load_stall);
    end
    @(posedge clk); #1;
    exp_cnt++;
    total++;
    if (WB_Write_data !== 32'hDEAD_BEEF || WB_Write_reg !== 5'd9
        || WB_RegWrite !== 1'b1) begin
      bad++;
      $display("FAIL held_data got=%h/%0d/%0b exp=deadbeef/9/1",
               WB_Write_data, WB_Write_reg, WB_RegWrite);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_rd0_bubble();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd0, 32'h55, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp_cnt++;
    total++;
    if (WB_RegWrite !== 1'b0 || retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL rd0 got=%0b/%0d exp=0/%0d",
               WB_RegWrite, retire_count, exp_cnt);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 5'd3, 32'h66, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    total++;
    if (WB_RegWrite !== 1'b0 || retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL bubble got=%0b/%0d exp=0/%0d",
               WB_RegWrite, retire_count, exp_cnt);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_rst_mid_wait();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd4, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd6, 32'h400, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (WB_RegWrite !== 1'b0 || WB_Write_reg !== 5'd0
        || WB_Write_data !== 32'h0 || retire_count !== 64'd0) begin
      bad++;
      $display("FAIL rst_async got=%0b/%0d/%h/%0d exp=0/0/0/0",
               WB_RegWrite, WB_Write_reg, WB_Write_data, retire_count);
    end
    @(negedge clk);
    idle_in();
    rst = 1'b0;
    exp_cnt = 0;
    dmif.dm_rvalid = 1'b1;
    dmif.dm_rdata  = 32'hFFFF_FFFF;
    stall_in       = 1'b1;
    @(posedge clk); #1;
    total++;
    if (WB_RegWrite !== 1'b0 || retire_count !== 64'd0) begin
      bad++;
      $display("FAIL stray_rv got=%0b/%0d exp=0/0", WB_RegWrite, retire_count);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd8, 32'h500, 1'b0, 32'h0, 1'b0);
    #1;
    total++;
    if (load_stall !== 1'b1) begin
      bad++; $display("FAIL post_rst_stall got=%0b exp=1", load_stall);
    end
    @(posedge clk);
    @(negedge clk);
    dmif.dm_rvalid = 1'b1;
    dmif.dm_rdata  = 32'h1122_3344;
    @(posedge clk); #1;
    exp_cnt++;
    total++;
    if (WB_Write_data !== 32'h1122_3344 || WB_RegWrite !== 1'b1
        || retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL post_rst_load got=%h/%0b/%0d exp=11223344/1/%0d",
               WB_Write_data, WB_RegWrite, retire_count, exp_cnt);
    end
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_cnt = 0;
    test_reset();
    test_alu();
    test_extract();
    test_late_load();
    test_held();
    test_rd0_bubble();
    test_rst_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
